bank_cmd_arbiter: RTL and testbench
===================================

Name: bank_cmd_arbiter

Overview:
- Shares the single DRAM command/address bus between the NUM_BANKS per-bank FSMs.
- Each cycle it grants at most one requesting bank and stalls the others.
- Inter-bank bus timing (tRRD, tCCD, tWTR, optional tFAW) is enforced by down-counters.
- It drives a registered command to the PHY-side command encoder.

Parameters:
NUM_BANKS, 8, number of bank FSM requesters (power of 2, 2..16)
ADDR_BITS, 16, row/column address width
T_RRD, 4, min cycles ACT->ACT (different banks)
T_CCD, 4, min cycles RD/WR->RD/WR
T_WTR, 6, min cycles WR->RD
T_FAW, 20, rolling window allowing at most 4 ACTs (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
bank_issue  in  NUM_BANKS  bank i requests the bus this cycle
bank_cmd  in  3*NUM_BANKS  per-bank command: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF; 6/7 illegal
bank_addr  in  ADDR_BITS*NUM_BANKS  per-bank row/col address
bank_stall  out  NUM_BANKS  combinational; bank i must hold its state this cycle
bank_grant  out  NUM_BANKS  combinational one-hot grant (all-zero when none)
cmd_valid  out  1  registered; command on bus valid
cmd_code  out  3  registered command code
cmd_ba  out  $clog2(NUM_BANKS)  registered bank index
cmd_addr  out  ADDR_BITS  registered address

Behaviour:
- Request filtering: req[i] = bank_issue[i] & (bank_cmd[i] in 1..5). Codes 0/6/7 never request and are never stalled.
- Eligibility:
  - ACT: rrd_cnt==0 (and FAW check when enabled).
  - RD: ccd_cnt==0 and wtr_cnt==0.
  - WR: ccd_cnt==0.
  - PRE: always eligible.
  - REF: always eligible.
- Priority:
  - Any eligible REF beats all other commands; lowest index wins among REFs.
  - Otherwise round-robin over eligible requesters, starting at rr_ptr. rr_ptr wraps modulo NUM_BANKS.
- Grant/stall:
  - bank_grant[w] = 1 for winner w.
  - bank_stall[i] = req[i] & ~bank_grant[i], combinational in the same cycle.
  - A granted bank advances its FSM on the next edge.
- rr_ptr update: on a grant, rr_ptr <= (w+1) mod NUM_BANKS (REF grants included). Otherwise it holds. Reset 0.
- Output latency: 1 cycle. On the edge after a grant:
  - cmd_valid=1, cmd_code, cmd_ba=w, and cmd_addr=bank_addr[w] (0 for PRE/REF).
  - With no grant: cmd_valid=0, cmd_code=0, cmd_ba and cmd_addr hold.
- Counters: width $clog2(max timing+1), saturating at 0, each decrements by 1 per cycle when nonzero.
  - On an ACT grant: rrd_cnt <= T_RRD-1.
  - On a RD/WR grant: ccd_cnt <= T_CCD-1.
  - On a WR grant: wtr_cnt <= T_WTR-1.
  - A load overrides the same-cycle decrement.
- Boundaries:
  - A T_* parameter of 1 means back-to-back is allowed (counter loads 0).
  - All requesters ineligible: no grant, all req banks stalled, counters keep decrementing.
  - Single requester: granted whenever eligible, regardless of rr_ptr.
- Reset (async, any time, mid-operation included):
  - Clears counters, rr_ptr, cmd_valid, cmd_code, cmd_ba and cmd_addr to 0.
  - With rst_n low, bank_grant=0 and bank_stall=bank_issue-filtered req.

Optional Feature:
- Macro: BANK_ARB_TFAW_EN.
- Defined:
  - Four ACT-age counters form a FIFO of timestamps. Each loads T_FAW-1 on an ACT grant into the oldest slot and decrements to 0.
  - ACT is eligible only if at least one slot is 0, in addition to rrd_cnt==0.
  - Slots reset to 0.
- Undefined: no FAW logic; ACT gated by tRRD only.

Test Plan:
- Banks 0,3,5 issue RD continuously from idle counters -> grants in order 0,3,5,0 spaced by T_CCD=4 cycles; cmd_valid one cycle after each grant; non-granted banks stall.
- Bank 2 issues WR at cycle 0, bank 4 issues RD from cycle 1 -> RD granted at cycle 6 (T_WTR=6), bus shows WR at cycle 1 and RD at cycle 7.
- Banks 1 and 6 issue ACT at cycle 0 -> bank 1 granted cycle 0, bank 6 granted cycle 4; cmd_addr equals each bank's row.
- Bank 7 issues REF while banks 0-3 issue RD -> bank 7 granted first, cmd_code=5, cmd_addr=0; rr_ptr becomes 0.
- With BANK_ARB_TFAW_EN, 5 banks issue ACT continuously -> ACTs at cycles 0,4,8,12, fifth held until cycle 20; without macro fifth at cycle 16.
- Assert rst_n low during a granted cycle with ccd_cnt=3 -> outputs and counters 0 immediately; after release, a RD is granted in the first cycle.

Source files
------------

// File: rtl/bank_cmd_arbiter.sv
// Shared DRAM command-bus arbiter: REF-first, then round-robin among eligible bank FSMs.
// Optional tFAW window enforcement is compiled in with `define BANK_ARB_TFAW_EN.
module bank_cmd_arbiter #(
    parameter int NUM_BANKS = 8,
    parameter int ADDR_BITS = 16,
    parameter int T_RRD     = 4,
    parameter int T_CCD     = 4,
    parameter int T_WTR     = 6,
    parameter int T_FAW     = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BANKS-1:0]           bank_issue_i,
    input  logic [3*NUM_BANKS-1:0]         bank_cmd_i,
    input  logic [ADDR_BITS*NUM_BANKS-1:0] bank_addr_i,
    output logic [NUM_BANKS-1:0]           bank_stall_o,
    output logic [NUM_BANKS-1:0]           bank_grant_o,
    output logic                           cmd_valid_o,
    output logic [2:0]                     cmd_code_o,
    output logic [$clog2(NUM_BANKS)-1:0]   cmd_ba_o,
    output logic [ADDR_BITS-1:0]           cmd_addr_o
);

    localparam int BW   = $clog2(NUM_BANKS);
    localparam int TM1  = (T_RRD > T_CCD) ? T_RRD : T_CCD;
    localparam int TM2  = (TM1 > T_WTR) ? TM1 : T_WTR;
    localparam int TMAX = (TM2 > T_FAW) ? TM2 : T_FAW;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;
    localparam logic [2:0] C_REF = 3'd5;

    logic [2:0]           cmd  [NUM_BANKS];
    logic [ADDR_BITS-1:0] addr [NUM_BANKS];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_unpack
        assign cmd[g]  = bank_cmd_i[3*g +: 3];
        assign addr[g] = bank_addr_i[ADDR_BITS*g +: ADDR_BITS];
    end

    logic [CW-1:0] rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d;
    logic [BW-1:0] rr_q, rr_d;
    logic                 valid_q, valid_d;
    logic [2:0]           code_q, code_d;
    logic [BW-1:0]        ba_q, ba_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;

    logic [NUM_BANKS-1:0] req, cand, is_ref;
    logic                 faw_ok, found, gnt_any;
    logic [BW-1:0]        win_idx, idx;
    logic [2:0]           win_cmd;

    // Eligibility against the inter-bank timing counters
    always_comb begin
        req    = '0;
        cand   = '0;
        is_ref = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            req[i]    = bank_issue_i[i] && (cmd[i] >= C_ACT) && (cmd[i] <= C_REF);
            is_ref[i] = req[i] && (cmd[i] == C_REF);
            case (cmd[i])
                C_ACT:        cand[i] = req[i] && (rrd_q == '0) && faw_ok;
                C_RD:         cand[i] = req[i] && (ccd_q == '0) && (wtr_q == '0);
                C_WR:         cand[i] = req[i] && (ccd_q == '0);
                C_PRE, C_REF: cand[i] = req[i];
                default:      cand[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!found && is_ref[i]) begin
                found   = 1'b1;
                win_idx = BW'(i);
            end
        end
        for (int k = 0; k < NUM_BANKS; k++) begin
            idx = rr_q + BW'(k);
            if (!found && cand[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Grant is suppressed while reset is held so no bank advances
    assign gnt_any      = found && rst_n;
    assign win_cmd      = cmd[win_idx];
    assign bank_grant_o = gnt_any ? (NUM_BANKS'(1) << win_idx) : '0;
    assign bank_stall_o = req & ~bank_grant_o;

    always_comb begin
        rr_d    = gnt_any ? (win_idx + BW'(1)) : rr_q;
        rrd_d   = (rrd_q != '0) ? (rrd_q - CW'(1)) : rrd_q;
        ccd_d   = (ccd_q != '0) ? (ccd_q - CW'(1)) : ccd_q;
        wtr_d   = (wtr_q != '0) ? (wtr_q - CW'(1)) : wtr_q;
        valid_d = gnt_any;
        code_d  = gnt_any ? win_cmd : 3'd0;
        ba_d    = gnt_any ? win_idx : ba_q;
        addr_d  = addr_q;
        if (gnt_any) begin
            addr_d = ((win_cmd == C_PRE) || (win_cmd == C_REF)) ? '0 : addr[win_idx];
            case (win_cmd)
                C_ACT: rrd_d = CW'(T_RRD - 1);
                C_RD:  ccd_d = CW'(T_CCD - 1);
                C_WR: begin
                    ccd_d = CW'(T_CCD - 1);
                    wtr_d = CW'(T_WTR - 1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= '0;
            rrd_q   <= '0;
            ccd_q   <= '0;
            wtr_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            ba_q    <= '0;
            addr_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            rrd_q   <= rrd_d;
            ccd_q   <= ccd_d;
            wtr_q   <= wtr_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
        end
    end

    assign cmd_valid_o = valid_q;
    assign cmd_code_o  = code_q;
    assign cmd_ba_o    = ba_q;
    assign cmd_addr_o  = addr_q;

`ifdef BANK_ARB_TFAW_EN
    // Four ACT ages in FIFO order; the oldest slot is reloaded on each ACT
    logic [CW-1:0] faw_q [4];
    logic [CW-1:0] faw_d [4];
    logic [1:0]    fptr_q, fptr_d;

    assign faw_ok = (faw_q[0] == '0) || (faw_q[1] == '0) ||
                    (faw_q[2] == '0) || (faw_q[3] == '0);

    always_comb begin
        fptr_d = fptr_q;
        for (int j = 0; j < 4; j++) begin
            faw_d[j] = (faw_q[j] != '0) ? (faw_q[j] - CW'(1)) : faw_q[j];
        end
        if (gnt_any && (win_cmd == C_ACT)) begin
            faw_d[fptr_q] = CW'(T_FAW - 1);
            fptr_d        = fptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fptr_q <= 2'd0;
            for (int j = 0; j < 4; j++) faw_q[j] <= '0;
        end else begin
            fptr_q <= fptr_d;
            for (int j = 0; j < 4; j++) faw_q[j] <= faw_d[j];
        end
    end
`else
    assign faw_ok = 1'b1;
`endif

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed bench for bank_cmd_arbiter: vector table for the cycle sequences,
// hand-written sequences for tFAW spacing and mid-operation asynchronous reset.
module tb_bank_cmd_arbiter;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   bank_issue = '0;
    logic [23:0]  bank_cmd = '0;
    logic [127:0] bank_addr;
    logic [7:0]   bank_stall, bank_grant;
    logic         cmd_valid;
    logic [2:0]   cmd_code, cmd_ba;
    logic [15:0]  cmd_addr;

    int n_cmp = 0;
    int n_fail = 0;

    bank_cmd_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bank_issue_i (bank_issue),
        .bank_cmd_i   (bank_cmd),
        .bank_addr_i  (bank_addr),
        .bank_stall_o (bank_stall),
        .bank_grant_o (bank_grant),
        .cmd_valid_o  (cmd_valid),
        .cmd_code_o   (cmd_code),
        .cmd_ba_o     (cmd_ba),
        .cmd_addr_o   (cmd_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  issue;
        logic [23:0] cmd;
        logic [7:0]  grant;
        logic [7:0]  stall;
        logic        valid;
        logic [2:0]  code;
        logic [2:0]  ba;
        logic [15:0] addr;
    } vec_t;

    vec_t tv[$];

    function automatic logic [23:0] cm(input logic [7:0] mask, input logic [2:0] c);
        logic [23:0] r = '0;
        for (int i = 0; i < 8; i++) if (mask[i]) r[3*i +: 3] = c;
        return r;
    endfunction

    function automatic vec_t mk(input logic rst, input logic [7:0] issue, input logic [23:0] cmd,
                                input logic [7:0] grant, input logic [7:0] stall, input logic valid,
                                input logic [2:0] code, input logic [2:0] ba, input logic [15:0] addr);
        vec_t v;
        v.rst = rst; v.issue = issue; v.cmd = cmd; v.grant = grant; v.stall = stall;
        v.valid = valid; v.code = code; v.ba = ba; v.addr = addr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        bank_issue = 8'h03;
        bank_cmd   = cm(8'h03, RD);
        #1;
        chk("rst_grant", 32'(bank_grant), 32'h0);
        chk("rst_stall", 32'(bank_stall), 32'h03);
        chk("rst_valid", 32'(cmd_valid), 32'h0);
        chk("rst_code",  32'(cmd_code),  32'h0);
        chk("rst_ba",    32'(cmd_ba),    32'h0);
        chk("rst_addr",  32'(cmd_addr),  32'h0);
        bank_issue = '0;
        bank_cmd   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int n);
        if (v.rst) do_reset();
        @(negedge clk);
        bank_issue = v.issue;
        bank_cmd   = v.cmd;
        #1;
        chk($sformatf("v%0d_grant", n), 32'(bank_grant), 32'(v.grant));
        chk($sformatf("v%0d_stall", n), 32'(bank_stall), 32'(v.stall));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_valid", n), 32'(cmd_valid), 32'(v.valid));
        chk($sformatf("v%0d_code", n),  32'(cmd_code),  32'(v.code));
        chk($sformatf("v%0d_ba", n),    32'(cmd_ba),    32'(v.ba));
        chk($sformatf("v%0d_addr", n),  32'(cmd_addr),  32'(v.addr));
    endtask

    initial begin
        logic [7:0] eg;
        for (int i = 0; i < 8; i++) bank_addr[16*i +: 16] = 16'hA000 + 16'(i);

        // Banks 0,3,5 RD continuously: grants 0,3,5,0 every T_CCD
        tv.push_back(mk(1, 8'h29, cm(8'h29, RD), 8'h01, 8'h28, 1, RD, 3'd0, 16'hA000));
        for (int t = 1; t < 4; t++) tv.push_back(mk(0, 8'h29, cm(8'h29, RD), 8'h00, 8'h29, 0, NOP, 3'd0, 16'hA000));
        tv.push_back(mk(0, 8'h29, cm(8'h29, RD), 8'h08, 8'h21, 1, RD, 3'd3, 16'hA003));
        for (int t = 5; t < 8; t++) tv.push_back(mk(0, 8'h29, cm(8'h29, RD), 8'h00, 8'h29, 0, NOP, 3'd3, 16'hA003));
        tv.push_back(mk(0, 8'h29, cm(8'h29, RD), 8'h20, 8'h09, 1, RD, 3'd5, 16'hA005));
        for (int t = 9; t < 12; t++) tv.push_back(mk(0, 8'h29, cm(8'h29, RD), 8'h00, 8'h29, 0, NOP, 3'd5, 16'hA005));
        tv.push_back(mk(0, 8'h29, cm(8'h29, RD), 8'h01, 8'h28, 1, RD, 3'd0, 16'hA000));
        // Codes 0/6/7 never request and never stall
        tv.push_back(mk(1, 8'h07, cm(8'h02, 3'd6) | cm(8'h04, 3'd7), 8'h00, 8'h00, 0, NOP, 3'd0, 16'h0000));
        // WR on bank 2 then RD on bank 4 waits out T_WTR
        tv.push_back(mk(1, 8'h04, cm(8'h04, WR), 8'h04, 8'h00, 1, WR, 3'd2, 16'hA002));
        for (int t = 1; t < 6; t++) tv.push_back(mk(0, 8'h10, cm(8'h10, RD), 8'h00, 8'h10, 0, NOP, 3'd2, 16'hA002));
        tv.push_back(mk(0, 8'h10, cm(8'h10, RD), 8'h10, 8'h00, 1, RD, 3'd4, 16'hA004));
        // ACT on banks 1 and 6 separated by T_RRD
        tv.push_back(mk(1, 8'h42, cm(8'h42, ACT), 8'h02, 8'h40, 1, ACT, 3'd1, 16'hA001));
        for (int t = 1; t < 4; t++) tv.push_back(mk(0, 8'h40, cm(8'h40, ACT), 8'h00, 8'h40, 0, NOP, 3'd1, 16'hA001));
        tv.push_back(mk(0, 8'h40, cm(8'h40, ACT), 8'h40, 8'h00, 1, ACT, 3'd6, 16'hA006));
        // REF on bank 7 beats RDs; pointer wraps to 0; PRE ignores tCCD
        tv.push_back(mk(1, 8'h8F, cm(8'h80, REF) | cm(8'h0F, RD), 8'h80, 8'h0F, 1, REF, 3'd7, 16'h0000));
        tv.push_back(mk(0, 8'h0F, cm(8'h0F, RD), 8'h01, 8'h0E, 1, RD, 3'd0, 16'hA000));
        tv.push_back(mk(0, 8'h2F, cm(8'h0F, RD) | cm(8'h20, PRE), 8'h20, 8'h0F, 1, PRE, 3'd5, 16'h0000));

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        foreach (tv[n]) apply(tv[n], n);

        // Five banks ACT back to back: tRRD spacing, fifth held by tFAW when enabled
        do_reset();
        @(negedge clk);
        bank_issue = 8'h1F;
        bank_cmd   = cm(8'h1F, ACT);
        for (int t = 0; t <= 20; t++) begin
            #1;
            eg = 8'h00;
`ifdef BANK_ARB_TFAW_EN
            if (t % 4 == 0 && t <= 12) eg = 8'(1 << (t / 4));
            if (t == 20) eg = 8'h10;
`else
            if (t % 4 == 0 && t <= 16) eg = 8'(1 << (t / 4));
            if (t == 20) eg = 8'h01;
`endif
            chk($sformatf("faw_t%0d_grant", t), 32'(bank_grant), 32'(eg));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a granted cycle with ccd_cnt=3
        do_reset();
        @(negedge clk);
        bank_issue = 8'h01;
        bank_cmd   = cm(8'h01, RD);
        #1 chk("ar_rd_grant", 32'(bank_grant), 32'h01);
        @(negedge clk);
        bank_issue = 8'h03;
        bank_cmd   = cm(8'h01, RD) | cm(8'h02, PRE);
        #1;
        chk("ar_pre_grant", 32'(bank_grant), 32'h02);
        chk("ar_pre_stall", 32'(bank_stall), 32'h01);
        chk("ar_pre_valid", 32'(cmd_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_low_grant", 32'(bank_grant), 32'h0);
        chk("ar_low_stall", 32'(bank_stall), 32'h03);
        chk("ar_low_valid", 32'(cmd_valid), 32'h0);
        chk("ar_low_code",  32'(cmd_code),  32'h0);
        chk("ar_low_ba",    32'(cmd_ba),    32'h0);
        chk("ar_low_addr",  32'(cmd_addr),  32'h0);
        bank_issue = '0;
        bank_cmd   = '0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        bank_issue = 8'h01;
        bank_cmd   = cm(8'h01, RD);
        #1 chk("ar_post_grant", 32'(bank_grant), 32'h01);
        @(posedge clk);
        #1;
        chk("ar_post_valid", 32'(cmd_valid), 32'h1);
        chk("ar_post_code",  32'(cmd_code),  32'(RD));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
